// File: rtl/vga_timing_rx.sv
//==============================================================================
// Module   : vga_timing_rx
// Brief    : VGA 800x525 timing receiver: locks to hsync/vsync, recovers x/y/de
//            and pixel data. Optional per-frame CRC-16 under VGA_RX_CRC_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        locked,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_start,
  output logic [11:0] h_meas,
  output logic [11:0] v_meas,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [11:0] c_H_TOTAL   = 12'(H_TOTAL);
  localparam logic [11:0] c_V_TOTAL   = 12'(V_TOTAL);
  localparam logic [11:0] c_H_TMO     = 12'(2 * H_TOTAL);
  localparam logic [11:0] c_V_TMO     = 12'(2 * V_TOTAL);
  localparam logic [11:0] c_H_ACT_BEG = 12'(H_ACT_START);
  localparam logic [11:0] c_H_ACT_END = 12'(H_ACT_START + H_ACTIVE);
  localparam logic [11:0] c_V_ACT_BEG = 12'(V_ACT_START);
  localparam logic [11:0] c_V_ACT_END = 12'(V_ACT_START + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_err_inc;

  logic        r_hs_d;
  logic        r_vs_d;
  logic [11:0] r_h_pos;
  logic [11:0] r_v_pos;

  logic        r_de;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_pix_r;
  logic [7:0]  r_pix_g;
  logic [7:0]  r_pix_b;
  logic        r_fs_pulse;
  logic [11:0] r_h_meas;
  logic [11:0] r_v_meas;
  logic [7:0]  r_err_count;

  logic        w_hs_lvl;
  logic        w_vs_lvl;
  logic        w_hs_rise;
  logic        w_fs;
  logic [11:0] w_h_len;
  logic [11:0] w_v_len;
  logic [11:0] w_h_next;
  logic [11:0] w_v_next;
  logic        w_h_to;
  logic        w_v_to;
  logic        w_h_bad;
  logic        w_v_bad;
  logic        w_lock_next;
  logic        w_h_in;
  logic        w_v_in;
  logic        w_de;
  logic [9:0]  w_x;
  logic [9:0]  w_y;

  // Sync levels normalised so that 1 always means "asserted"
  assign w_hs_lvl  = (hsync == SYNC_POL);
  assign w_vs_lvl  = (vsync == SYNC_POL);
  assign w_hs_rise = pix_en & w_hs_lvl & ~r_hs_d;
  // vsync is only judged at line starts, so r_vs_d tracks its level at the last hs_rise
  assign w_fs      = w_hs_rise & w_vs_lvl & ~r_vs_d;

  assign w_h_len   = r_h_pos + 12'd1;
  assign w_v_len   = r_v_pos + 12'd1;

  always_comb begin
    w_h_next = r_h_pos;
    if (w_hs_rise) begin
      w_h_next = '0;
    end else if (r_h_pos != c_H_TMO) begin
      w_h_next = r_h_pos + 12'd1;
    end
  end

  always_comb begin
    w_v_next = r_v_pos;
    if (w_fs) begin
      w_v_next = '0;
    end else if (w_hs_rise && (r_v_pos != c_V_TMO)) begin
      w_v_next = r_v_pos + 12'd1;
    end
  end

  assign w_h_to  = pix_en & ~w_hs_rise & (w_h_next == c_H_TMO);
  assign w_v_to  = pix_en & ~w_fs & (w_v_next == c_V_TMO);
  assign w_h_bad = w_hs_rise & (w_h_len != c_H_TOTAL);
  assign w_v_bad = w_fs & (w_v_len != c_V_TOTAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_fs) begin
          w_state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (w_fs && (w_h_len == c_H_TOTAL) && (w_v_len == c_V_TOTAL)) begin
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_h_bad || w_v_bad) begin
          w_state_next = ST_SEARCH;
          w_err_inc    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_SEARCH;
      end
    endcase
    // A timeout on the same sample as a mismatch still counts as one loss
    if (w_h_to || w_v_to) begin
      w_state_next = ST_SEARCH;
      if (r_state == ST_LOCKED) begin
        w_err_inc = 1'b1;
      end
    end
  end

  assign w_lock_next = (w_state_next == ST_LOCKED);
  assign w_h_in      = (w_h_next >= c_H_ACT_BEG) && (w_h_next < c_H_ACT_END);
  assign w_v_in      = (w_v_next >= c_V_ACT_BEG) && (w_v_next < c_V_ACT_END);
  assign w_de        = w_lock_next & w_h_in & w_v_in;
  assign w_x         = 10'(w_h_next - c_H_ACT_BEG);
  assign w_y         = 10'(w_v_next - c_V_ACT_BEG);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_d      <= 1'b0;
      r_vs_d      <= 1'b0;
      r_h_pos     <= '0;
      r_v_pos     <= '0;
      r_de        <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_pix_r     <= '0;
      r_pix_g     <= '0;
      r_pix_b     <= '0;
      r_fs_pulse  <= 1'b0;
      r_h_meas    <= '0;
      r_v_meas    <= '0;
      r_err_count <= '0;
    end else begin
      r_fs_pulse <= w_fs;
      if (pix_en) begin
        r_hs_d  <= w_hs_lvl;
        r_h_pos <= w_h_next;
        r_v_pos <= w_v_next;
        if (w_hs_rise) begin
          r_vs_d   <= w_vs_lvl;
          r_h_meas <= w_h_len;
        end
        if (w_fs) begin
          r_v_meas <= w_v_len;
        end
        if (w_err_inc && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
        r_de    <= w_de;
        r_x     <= w_de ? w_x   : '0;
        r_y     <= w_de ? w_y   : '0;
        r_pix_r <= w_de ? red   : '0;
        r_pix_g <= w_de ? green : '0;
        r_pix_b <= w_de ? blue  : '0;
      end
    end
  end

  assign locked      = (r_state == ST_LOCKED);
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign pix_r       = r_pix_r;
  assign pix_g       = r_pix_g;
  assign pix_b       = r_pix_b;
  assign frame_start = r_fs_pulse;
  assign h_meas      = r_h_meas;
  assign v_meas      = r_v_meas;
  assign err_count   = r_err_count;

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] f_crc16_step(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] v;
    v = crc;
    for (int i = 23; i >= 0; i--) begin
      if (v[15] ^ data[i]) begin
        v = {v[14:0], 1'b0} ^ 16'h1021;
      end else begin
        v = {v[14:0], 1'b0};
      end
    end
    return v;
  endfunction

  logic [15:0] r_crc_acc;
  logic [15:0] r_frame_crc;
  logic        r_full_lock;

  // r_full_lock: the frame in progress began locked and has stayed locked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc_acc   <= 16'hFFFF;
      r_frame_crc <= '0;
      r_full_lock <= 1'b0;
    end else if (pix_en) begin
      if (w_fs) begin
        r_frame_crc <= r_full_lock ? r_crc_acc : 16'h0000;
        r_crc_acc   <= 16'hFFFF;
        r_full_lock <= w_lock_next;
      end else begin
        if (!w_lock_next) begin
          r_full_lock <= 1'b0;
        end
        if (w_de) begin
          r_crc_acc <= f_crc16_step(r_crc_acc, {red, green, blue});
        end
      end
    end
  end

  assign frame_crc = r_frame_crc;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the board's VGA timing generator.
- Samples hsync/vsync/RGB on pixel-enable strobes and checks the frame against the 800x525 timing.
- Locks when one full frame matches; then recovers x/y pixel coordinates, a data-enable and registered pixel data.
- Used as a loopback checker and capture front-end for the VGA output path.

Parameters:
- H_TOTAL, 800, pixel samples per line
- V_TOTAL, 525, lines per frame
- H_ACT_START, 144, first active column (h_pos)
- H_ACTIVE, 640, active columns
- V_ACT_START, 35, first active line (v_pos)
- V_ACTIVE, 480, active lines
- SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_en  in  1  one-cycle strobe per pixel (25 MHz rate); all sampling only on pix_en cycles
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- red/green/blue  in  8 each  pixel data
- locked  out  1  timing matched and tracking
- de  out  1  current pixel is active
- x  out  10  active column, 0..H_ACTIVE-1
- y  out  10  active line, 0..V_ACTIVE-1
- pix_r/pix_g/pix_b  out  8 each  registered pixel data
- frame_start  out  1  one-cycle pulse at frame boundary
- h_meas  out  12  length of last complete line
- v_meas  out  12  length of last complete frame, in lines
- err_count  out  8  saturating count of lock losses
- frame_crc  out  16  see Optional Feature

Behaviour:
- Reset: synchronous active-high; takes precedence over pix_en. All outputs, counters and edge registers reset to 0; state = SEARCH.
- Edge detect: hs_d/vs_d hold the previous sampled levels (polarity normalised by SYNC_POL). A line start (hs_rise) is a pix_en sample with hsync asserted and hs_d deasserted.
- Horizontal position:
  - h_pos = 0 on the hs_rise sample; otherwise +1 per pix_en.
  - On hs_rise, h_meas <= previous h_pos + 1.
- Frame start (fs): an hs_rise sample where vsync is asserted and vsync at the previous hs_rise was deasserted.
- Vertical position:
  - v_pos = 0 on fs; otherwise +1 on each hs_rise.
  - On fs, v_meas <= previous v_pos + 1.
- States:
  - SEARCH: locked=0; first fs -> MEASURE.
  - MEASURE: at next fs, if h_meas == H_TOTAL and v_meas == V_TOTAL -> LOCKED; else stay in MEASURE.
  - LOCKED: any hs_rise with h_meas != H_TOTAL, or fs with v_meas != V_TOTAL -> SEARCH, err_count +1 (saturates at 255).
- Timeouts: h_pos reaching 2*H_TOTAL without hs_rise, or v_pos reaching 2*V_TOTAL without fs, forces SEARCH. Counts err_count only if previously LOCKED. Counters hold at the timeout value until the next edge.
- Simultaneous events: a mismatch and a timeout on the same sample increment err_count once.
- Outputs (registered, 1 clk after the qualifying pix_en sample; held between strobes):
  - de = locked & h_pos in [H_ACT_START, H_ACT_START+H_ACTIVE) & v_pos in [V_ACT_START, V_ACT_START+V_ACTIVE).
  - x = h_pos-H_ACT_START and y = v_pos-V_ACT_START when de, else 0.
  - pix_* = sampled RGB when de, else 0.
- frame_start: pulses one clk after every fs sample, in any state.
- locked: rises on the clk after the matching fs. The first de occurs in that same frame.
- Reset mid-frame: state returns to SEARCH, and lock needs a full new frame after the first fs.

Optional Feature:
- Macro: VGA_RX_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulated over {pix_r,pix_g,pix_b}, MSB first, for each de pixel.
  - frame_crc latches the final value of the just-ended frame on fs; the accumulator reinitialises on the same sample.
  - frame_crc is valid when frame_start pulses; it is 0 until the first full locked frame.
- Undefined: frame_crc is tied to 0 and no CRC logic is built.

Test Plan:
- Reset then 3 frames of 800x525 timing, hsync high for h 0..95, vsync high for lines 0..1 -> locked=1 one clk after 2nd fs; h_meas=800, v_meas=525; err_count=0.
- Locked; pixel at h=144, v=35 with RGB 0x00BB2D -> de=1, x=0, y=0, pix_g=0xBB; at h=783, v=514 -> x=639, y=479; at h=784 -> de=0.
- Locked; inject one 799-sample line -> locked=0 after that hs_rise, err_count=1; relock after two clean fs.
- Hold hsync deasserted for 1600 samples while locked -> SEARCH, err_count+1; repeat 300 losses -> err_count saturates at 255.
- Assert rst mid-frame with pix_en=1 on the same cycle -> all outputs 0 next clk; no lock before a full frame after the next fs.
- VGA_RX_CRC_EN defined; constant white active area -> identical nonzero frame_crc each frame; flip one pixel -> frame_crc differs for that frame only.
